// File: rtl/sub_flag_stage_pkg.sv
// Shared definitions for the subtractor flag stage and the branch unit:
// status layout, flag bit positions and the 16 condition codes.
package sub_flag_stage_pkg;

  // Status / flag register width and bit positions ({V,C,N,Z}).
  localparam int ST_W   = 4;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // Condition-code encodings. Codes 11..15 all mean "never".
  localparam logic [3:0] COND_EQ  = 4'd0;
  localparam logic [3:0] COND_NE  = 4'd1;
  localparam logic [3:0] COND_LTU = 4'd2;
  localparam logic [3:0] COND_GEU = 4'd3;
  localparam logic [3:0] COND_LT  = 4'd4;
  localparam logic [3:0] COND_GE  = 4'd5;
  localparam logic [3:0] COND_MI  = 4'd6;
  localparam logic [3:0] COND_VS  = 4'd7;
  localparam logic [3:0] COND_AL  = 4'd8;
  localparam logic [3:0] COND_GT  = 4'd9;
  localparam logic [3:0] COND_LE  = 4'd10;
  localparam logic [3:0] COND_NV  = 4'd11;

endpackage

// File: rtl/sub_cond_eval.sv
// Combinational branch-condition evaluator: flags + condition code -> taken.
// Shared with the branch unit, so it carries no state.
module sub_cond_eval
  import sub_flag_stage_pkg::*;
(
  input  logic [ST_W-1:0] i_flags,
  input  logic [3:0]      i_cond,
  output logic            o_taken
);

  logic w_z;
  logic w_n;
  logic w_c;
  logic w_v;
  logic w_lt;

  assign w_z  = i_flags[FLAG_Z];
  assign w_n  = i_flags[FLAG_N];
  assign w_c  = i_flags[FLAG_C];
  assign w_v  = i_flags[FLAG_V];
  // Signed less-than after a subtract: sign disagrees with overflow.
  assign w_lt = w_n ^ w_v;

  // Decode the condition code against the current flags.
  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_EQ:  o_taken = w_z;
      COND_NE:  o_taken = ~w_z;
      COND_LTU: o_taken = w_c;
      COND_GEU: o_taken = ~w_c;
      COND_LT:  o_taken = w_lt;
      COND_GE:  o_taken = ~w_lt;
      COND_MI:  o_taken = w_n;
      COND_VS:  o_taken = w_v;
      COND_AL:  o_taken = 1'b1;
      COND_GT:  o_taken = ~w_z & ~w_lt;
      COND_LE:  o_taken = w_z | w_lt;
      default:  o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sub_flag_stage.sv
// Pipeline stage after the 8-bit subtractor: registers the result for
// writeback, owns the architectural flag register, resolves branch
// conditions against it, and tracks overflow events (sticky + counter).
module sub_flag_stage
  import sub_flag_stage_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RD_W  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_res,
  input  logic [ST_W-1:0]  in_st,
  input  logic             in_setf,
  input  logic             in_branch,
  input  logic [3:0]       in_cond,
  input  logic [RD_W-1:0]  in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_wen,
  output logic             out_taken,
  output logic [ST_W-1:0]  flags,
  input  logic             clr_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_res;
  logic [RD_W-1:0]  r_out_rd;
  logic             r_out_wen;
  logic             r_out_taken;
  logic [ST_W-1:0]  r_flags;
  logic             r_ovf_sticky;
  logic [CNT_W-1:0] r_ovf_count;

  logic w_in_ready;
  logic w_accept;
  logic w_cond_taken;
  logic w_ovf_event;

  // A held beat blocks acceptance unless writeback takes it this cycle;
  // flush blocks acceptance outright.
  assign w_in_ready  = ~flush & (~r_out_valid | out_ready);
  assign w_accept    = in_valid & w_in_ready;
  assign w_ovf_event = w_accept & in_setf & in_st[FLAG_V];

  // Branch conditions see the flags as they were before this beat, even
  // when the same beat also updates them.
  sub_cond_eval u_cond_eval (
    .i_flags (r_flags),
    .i_cond  (in_cond),
    .o_taken (w_cond_taken)
  );

  // Output pipeline register: load on accept, drop on handoff or flush,
  // otherwise hold everything stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
      r_out_rd    <= '0;
      r_out_wen   <= 1'b0;
      r_out_taken <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_res   <= in_res;
      r_out_rd    <= in_rd;
      r_out_wen   <= ~in_branch;
      r_out_taken <= in_branch & w_cond_taken;
    end else if (flush | out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Architectural flag register; flush never rolls it back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else if (w_accept && in_setf) begin
      r_flags <= in_st;
    end
  end

  // Sticky overflow and saturating event counter; an event in the same
  // cycle as a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= '0;
    end else if (w_ovf_event) begin
      r_ovf_sticky <= 1'b1;
      if (clr_ovf) begin
        r_ovf_count <= CNT_ONE;
      end else if (r_ovf_count != CNT_MAX) begin
        r_ovf_count <= r_ovf_count + CNT_ONE;
      end
    end else if (clr_ovf) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= '0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_res    = r_out_res;
  assign out_rd     = r_out_rd;
  assign out_wen    = r_out_wen;
  assign out_taken  = r_out_taken;
  assign flags      = r_flags;
  assign ovf_sticky = r_ovf_sticky;
  assign ovf_count  = r_ovf_count;

endmodule

// File: tb/tb_sub_flag_stage.sv
// Bench for sub_flag_stage: directed scenarios followed by random traffic,
// with a queue-based scoreboard for writeback beats and a behavioural model
// of flags and overflow state.
module tb_sub_flag_stage;
  import sub_flag_stage_pkg::*;

  localparam int WIDTH = 8;
  localparam int RD_W  = 3;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, flush, in_valid, in_ready;
  logic [WIDTH-1:0] in_res;
  logic [3:0]       in_st;
  logic             in_setf, in_branch;
  logic [3:0]       in_cond;
  logic [RD_W-1:0]  in_rd;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_res;
  logic [RD_W-1:0]  out_rd;
  logic             out_wen, out_taken;
  logic [3:0]       flags;
  logic             clr_ovf, ovf_sticky;
  logic [CNT_W-1:0] ovf_count;

  sub_flag_stage #(.WIDTH(WIDTH), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_res(in_res), .in_st(in_st), .in_setf(in_setf), .in_branch(in_branch),
    .in_cond(in_cond), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_rd(out_rd), .out_wen(out_wen), .out_taken(out_taken),
    .flags(flags), .clr_ovf(clr_ovf), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [RD_W-1:0]  rd;
    logic             wen;
    logic             taken;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    tests = 0;
  int    fails = 0;

  // Reference state
  logic [3:0] m_flags  = '0;
  logic       m_sticky = 1'b0;
  int         m_count  = 0;
  logic       m_valid  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Branch semantics from the condition table, phrased as comparisons.
  function automatic logic cond_model(input logic [3:0] f, input logic [3:0] c);
    logic z, n, cy, v, slt;
    z = f[0]; n = f[1]; cy = f[2]; v = f[3];
    slt = (n != v);
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return slt;
      4'd5:  return !slt;
      4'd6:  return n;
      4'd7:  return v;
      4'd8:  return 1'b1;
      4'd9:  return !z && !slt;
      4'd10: return z || slt;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: every writeback handshake retires the oldest expected beat.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got res=%0h with no beat expected at %0t", out_res, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_res", 32'(out_res), 32'(mon_e.res));
        check("beat_rd", 32'(out_rd), 32'(mon_e.rd));
        check("beat_wen", 32'(out_wen), 32'(mon_e.wen));
        check("beat_taken", 32'(out_taken), 32'(mon_e.taken));
      end
    end
  end

  task automatic idle_inputs();
    rst = 0; flush = 0; in_valid = 0; in_res = '0; in_st = '0; in_setf = 0;
    in_branch = 0; in_cond = '0; in_rd = '0; out_ready = 1; clr_ovf = 0;
  endtask

  task automatic set_beat(input logic [7:0] res, input logic [3:0] st, input logic setf,
                          input logic br, input logic [3:0] c, input logic [2:0] rd);
    in_valid = 1; in_res = res; in_st = st; in_setf = setf;
    in_branch = br; in_cond = c; in_rd = rd;
  endtask

  // One clock: predict, clock, update model, check persistent state.
  task automatic tick();
    logic acc, ev;
    #1;
    acc = in_valid && !flush && (!m_valid || out_ready);
    if (!rst) check("in_ready", 32'(in_ready), 32'(!flush && (!m_valid || out_ready)));
    @(posedge clk);
    if (rst) begin
      m_flags = '0; m_sticky = 0; m_count = 0; m_valid = 0;
      exp_q.delete();
    end else begin
      ev = acc && in_setf && in_st[3];
      if (acc) begin
        exp_q.push_back('{res: in_res, rd: in_rd, wen: !in_branch,
                          taken: in_branch && cond_model(m_flags, in_cond)});
        if (in_setf) m_flags = in_st;
        m_valid = 1;
      end else if (flush || out_ready) begin
        if (flush && m_valid && !out_ready && exp_q.size() > 0) void'(exp_q.pop_back());
        m_valid = 0;
      end
      if (ev) begin
        m_sticky = 1;
        m_count  = clr_ovf ? 1 : ((m_count < 255) ? m_count + 1 : 255);
      end else if (clr_ovf) begin
        m_sticky = 0;
        m_count  = 0;
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("flags", 32'(flags), 32'(m_flags));
    check("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
    check("ovf_count", 32'(ovf_count), 32'(m_count));
  endtask

  logic [7:0] held_res;

  initial begin
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_res", 32'(out_res), 0);
    check("rst_out_rd", 32'(out_rd), 0);
    check("rst_out_wen", 32'(out_wen), 0);
    check("rst_out_taken", 32'(out_taken), 0);
    check("rst_flags", 32'(flags), 0);
    check("rst_ovf", 32'({ovf_sticky, ovf_count}), 0);

    // 1: 1-1 sets Z, then branch EQ is taken
    set_beat(8'h00, 4'b0001, 1, 0, 4'd0, 3'd1); tick();
    set_beat(8'h00, 4'b0000, 0, 1, COND_EQ, 3'd2); tick();
    idle_inputs();
    check("t1_flags", 32'(flags), 32'h1);
    check("t1_taken", 32'(out_taken), 1);
    check("t1_wen", 32'(out_wen), 0);
    tick();

    // 2: 120-(-9) overflows; LT not taken, VS taken
    set_beat(8'h81, 4'b1110, 1, 0, 4'd0, 3'd3); tick();
    check("t2_flags", 32'(flags), 32'hE);
    check("t2_sticky", 32'(ovf_sticky), 1);
    check("t2_count", 32'(ovf_count), 1);
    set_beat(8'h00, 4'b0000, 0, 1, COND_LT, 3'd0); tick();
    check("t2_lt", 32'(out_taken), 0);
    set_beat(8'h00, 4'b0000, 0, 1, COND_VS, 3'd0); tick();
    check("t2_vs", 32'(out_taken), 1);
    idle_inputs(); tick();

    // 3: stall with 126 held for 3 cycles while upstream waits
    set_beat(8'd126, 4'b0000, 0, 0, 4'd0, 3'd5); tick();
    out_ready = 0;
    set_beat(8'h11, 4'b0000, 0, 0, 4'd0, 3'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_in_ready", 32'(in_ready), 0);
      check("t3_res_held", 32'(out_res), 32'd126);
      check("t3_rd_held", 32'(out_rd), 32'd5);
    end
    out_ready = 1; tick();
    idle_inputs();
    check("t3_next_res", 32'(out_res), 32'h11);
    check("t3_next_valid", 32'(out_valid), 1);
    tick();

    // 4: setf+branch on one beat uses the old flags
    set_beat(8'h00, 4'b0000, 1, 0, 4'd0, 3'd0); tick();
    set_beat(8'h00, 4'b0001, 1, 1, COND_EQ, 3'd0); tick();
    idle_inputs();
    check("t4_taken", 32'(out_taken), 0);
    check("t4_flags", 32'(flags), 32'h1);
    tick();

    // 5: saturation after 256 events, then clear together with an event
    clr_ovf = 1; tick(); clr_ovf = 0;
    for (int i = 0; i < 256; i++) begin
      set_beat(8'(i), 4'b1000, 1, 0, 4'd0, 3'(i)); tick();
    end
    check("t5_sat", 32'(ovf_count), 32'hFF);
    clr_ovf = 1; tick();
    check("t5_clr_evt_count", 32'(ovf_count), 1);
    check("t5_clr_evt_sticky", 32'(ovf_sticky), 1);
    idle_inputs(); tick();

    // 6: flush drops the held beat and accepts nothing
    set_beat(8'h2B, 4'b0000, 0, 0, 4'd0, 3'd4); tick();
    out_ready = 0; flush = 1; set_beat(8'h77, 4'b0000, 0, 0, 4'd0, 3'd1); tick();
    check("t6_flush_valid", 32'(out_valid), 0);
    flush = 0; in_valid = 0; tick();
    check("t6_no_accept", 32'(out_valid), 0);
    // reset in the middle of a stall
    set_beat(8'h5A, 4'b1111, 1, 0, 4'd0, 3'd7); tick();
    in_valid = 0; rst = 1; tick(); rst = 0;
    check("t6_rst_all", 32'({out_valid, out_res, out_rd, out_wen, out_taken, flags, ovf_sticky, ovf_count}), 0);
    idle_inputs();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_res    = 8'($urandom);
      in_st     = 4'($urandom);
      in_setf   = 1'($urandom);
      in_branch = 1'($urandom);
      in_cond   = 4'($urandom);
      in_rd     = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      clr_ovf   = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end

    idle_inputs();
    tick(); tick(); tick();
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
